// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback passes straight through,
// multi-cycle results queue in a small FIFO and drain into idle or forced slots.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pipe_write_en,
  input  logic [4:0]  i_pipe_dest,
  input  logic [31:0] i_pipe_data,
  input  logic        i_async_valid,
  input  logic [4:0]  i_async_dest,
  input  logic [31:0] i_async_data,
  output logic        o_async_ready,
  output logic        o_pipe_stall,
  input  logic [4:0]  i_query_reg,
  output logic        o_query_pending,
  output logic        o_reg_write_en,
  output logic [4:0]  o_reg_write_dest,
  output logic [31:0] o_reg_write_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

  typedef enum logic {ST_NORMAL, ST_DRAIN} state_t;

  logic [4:0]       r_dest [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;
  state_t           r_state;
  state_t           w_next_state;

  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_pipe_req;
  logic [4:0]       w_head_dest;
  logic [31:0]      w_head_data;
  logic [DEPTH-1:0] w_valid;
  logic [PW-1:0]    w_offs;

  assign w_empty       = (r_count == '0);
  assign w_pipe_req    = i_pipe_write_en && (i_pipe_dest != 5'd0);
  assign w_head_dest   = r_dest[r_rd_ptr];
  assign w_head_data   = r_data[r_rd_ptr];
  assign o_async_ready = !i_rst && (r_count < DEPTH_C);
  assign w_push        = i_async_valid && o_async_ready;

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    w_valid = '0;
    w_offs  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_offs     = PW'(i) - r_rd_ptr;
      w_valid[i] = ({1'b0, w_offs} < r_count);
    end
  end

  always_comb begin
    o_query_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (r_dest[i] == i_query_reg)) begin
        o_query_pending = 1'b1;
      end
    end
    if (i_rst || (i_query_reg == 5'd0)) begin
      o_query_pending = 1'b0;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_pop            = 1'b0;
    o_pipe_stall     = 1'b0;
    o_reg_write_en   = 1'b0;
    o_reg_write_dest = 5'd0;
    o_reg_write_data = 32'd0;
    if (!i_rst) begin
      case (r_state)
        ST_NORMAL: begin
          if (w_pipe_req) begin
            o_reg_write_en   = 1'b1;
            o_reg_write_dest = i_pipe_dest;
            o_reg_write_data = i_pipe_data;
          end else if (!w_empty) begin
            w_pop            = 1'b1;
            o_reg_write_en   = (w_head_dest != 5'd0);
            o_reg_write_dest = w_head_dest;
            o_reg_write_data = w_head_data;
          end
          if ((r_starve == STARVE_MAX) && !w_empty && !w_pop) begin
            w_next_state = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          o_pipe_stall = 1'b1;
          if (!w_empty) begin
            w_pop            = 1'b1;
            o_reg_write_en   = (w_head_dest != 5'd0);
            o_reg_write_dest = w_head_dest;
            o_reg_write_data = w_head_data;
          end
          w_next_state = ST_NORMAL;
        end
        default: w_next_state = ST_NORMAL;
      endcase
    end
  end

  // Entry storage needs no reset; liveness comes from the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_dest[r_wr_ptr] <= i_async_dest;
      r_data[r_wr_ptr] <= i_async_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_state  <= ST_NORMAL;
    end else begin
      r_state <= w_next_state;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_pop || w_empty) begin
        r_starve <= '0;
      end else if (r_starve != STARVE_MAX) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed plus randomized bench for wb_port_arbiter, checked each cycle
// against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipeWriteEn;
  logic [4:0]  pipeDest;
  logic [31:0] pipeData;
  logic        asyncValid;
  logic [4:0]  asyncDest;
  logic [31:0] asyncData;
  logic        asyncReady;
  logic        pipeStall;
  logic [4:0]  queryReg;
  logic        queryPending;
  logic        regWriteEn;
  logic [4:0]  regWriteDest;
  logic [31:0] regWriteData;

  int checkCount = 0;
  int passCount  = 0;

  logic [4:0]  mDest [$];
  logic [31:0] mData [$];
  int          mStarve = 0;
  bit          mDrain  = 1'b0;

  logic        eWe, eStall, eReady, ePending, ePop, ePush;
  logic [4:0]  eDest;
  logic [31:0] eData;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_pipe_write_en  (pipeWriteEn),
    .i_pipe_dest      (pipeDest),
    .i_pipe_data      (pipeData),
    .i_async_valid    (asyncValid),
    .i_async_dest     (asyncDest),
    .i_async_data     (asyncData),
    .o_async_ready    (asyncReady),
    .o_pipe_stall     (pipeStall),
    .i_query_reg      (queryReg),
    .o_query_pending  (queryPending),
    .o_reg_write_en   (regWriteEn),
    .o_reg_write_dest (regWriteDest),
    .o_reg_write_data (regWriteData)
  );

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
  endtask

  // Port contents this cycle, derived from the queue and the drain flag.
  task automatic modelOutputs();
    eWe = 0; eDest = 0; eData = 0; eStall = 0; eReady = 0; ePending = 0; ePop = 0; ePush = 0;
    if (!rst) begin
      eReady = (mDest.size() < DEPTH);
      ePush  = asyncValid && eReady;
      foreach (mDest[k]) if ((mDest[k] == queryReg) && (queryReg != 0)) ePending = 1;
      if (mDrain) begin
        eStall = 1;
        if (mDest.size() > 0) begin
          ePop = 1; eWe = (mDest[0] != 0); eDest = mDest[0]; eData = mData[0];
        end
      end else if (pipeWriteEn && (pipeDest != 0)) begin
        eWe = 1; eDest = pipeDest; eData = pipeData;
      end else if (mDest.size() > 0) begin
        ePop = 1; eWe = (mDest[0] != 0); eDest = mDest[0]; eData = mData[0];
      end
    end
  endtask

  task automatic modelAdvance();
    bit wasEmpty;
    bit goDrain;
    if (rst) begin
      mDest.delete(); mData.delete(); mStarve = 0; mDrain = 0;
    end else begin
      wasEmpty = (mDest.size() == 0);
      goDrain  = !mDrain && (mStarve == STARVE_LIMIT - 1) && !wasEmpty && !ePop;
      if (ePop) begin
        void'(mDest.pop_front()); void'(mData.pop_front());
      end
      if (ePush) begin
        mDest.push_back(asyncDest); mData.push_back(asyncData);
      end
      if (ePop || wasEmpty) mStarve = 0;
      else if (mStarve < STARVE_LIMIT - 1) mStarve++;
      mDrain = mDrain ? 1'b0 : goDrain;
    end
  endtask

  task automatic checkOutput();
    checkOne("reg_write_en", 32'(regWriteEn), 32'(eWe));
    if (eWe || rst) begin
      checkOne("reg_write_dest", 32'(regWriteDest), 32'(eDest));
      checkOne("reg_write_data", regWriteData, eData);
    end
    checkOne("pipe_stall", 32'(pipeStall), 32'(eStall));
    checkOne("async_ready", 32'(asyncReady), 32'(eReady));
    checkOne("query_pending", 32'(queryPending), 32'(ePending));
  endtask

  task automatic applyStimulus(input logic r, input logic pwe, input logic [4:0] pd,
                               input logic [31:0] pdat, input logic av, input logic [4:0] ad,
                               input logic [31:0] adat, input logic [4:0] q);
    rst = r; pipeWriteEn = pwe; pipeDest = pd; pipeData = pdat;
    asyncValid = av; asyncDest = ad; asyncData = adat; queryReg = q;
    #1;
    modelOutputs();
    checkOutput();
    @(posedge clk);
    modelAdvance();
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(1, 1, 5'd5, 32'hdead, 1, 5'd3, 32'h1, 5'd3);
    applyStimulus(1, 1, 5'd5, 32'hdead, 1, 5'd3, 32'h1, 5'd3);

    $display("[TB] pipe pass-through");
    applyStimulus(0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'h0, 5'd0);

    $display("[TB] single async result with idle pipe");
    applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'hAA, 5'd7);
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7);
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7);

    $display("[TB] fill FIFO under a busy pipe and force drain");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 5'(i + 1), 32'h100 + i, 1, 5'(10 + i), 32'h200 + i, 5'd0);
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 1, 5'd20, 32'h300 + i, 0, 5'd0, 32'h0, 5'(10 + (i % 4)));

    $display("[TB] full FIFO with idle pipe and offered result");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 5'd21, 32'h400 + i, 1, 5'(14 + i), 32'h500 + i, 5'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'(24 + i), 32'h600 + i, 5'd0);
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0);

    $display("[TB] pending lookup");
    applyStimulus(0, 1, 5'd4, 32'h44, 1, 5'd9, 32'h99, 5'd9);
    applyStimulus(0, 1, 5'd4, 32'h45, 0, 5'd0, 32'h0, 5'd9);
    applyStimulus(0, 1, 5'd4, 32'h46, 0, 5'd0, 32'h0, 5'd0);
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9);
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9);

    $display("[TB] dest zero handling and mid-operation reset");
    applyStimulus(0, 1, 5'd6, 32'h66, 1, 5'd12, 32'hC0, 5'd0);
    applyStimulus(0, 1, 5'd0, 32'h77, 0, 5'd0, 32'h0, 5'd12);
    applyStimulus(0, 1, 5'd6, 32'h66, 1, 5'd0, 32'hD0, 5'd0);
    applyStimulus(0, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 5'd0);
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 5'd8, 32'h800 + i, 1, 5'(16 + i), 32'h900 + i, 5'd17);
    applyStimulus(1, 1, 5'd8, 32'h888, 1, 5'd19, 32'h999, 5'd17);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'(16 + i));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(63, 0) == 0),
                    ($urandom_range(3, 0) != 0),
                    5'($urandom_range(15, 0)),
                    $urandom(),
                    ($urandom_range(1, 0) == 1),
                    5'($urandom_range(15, 0)),
                    $urandom(),
                    5'($urandom_range(15, 0)));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
